aes256_keyexp_ctrl: RTL and testbench
=====================================

// Module: aes256_keyexp_ctrl
// PURPOSE
//  Sequences roundkeygen_1lane through a full AES-256 key expansion and emits 15 round keys (RK0..RK14) on a valid/ready stream.
//  Owns the 8-word sliding window and the rcon/use_rcon state.
//  Arbitrates the single shared S-box between the key generator and the cipher round datapath.
// PARAMETERS
//  NUM_RK   15  round keys emitted per key_load; legal 2..15 (15 = full AES-256 schedule)
//  RCON_IDX0 0  rcon index presented with the first generator start
// PORTS
//  clk             in   1    clock
//  rst             in   1    synchronous, active-high reset; generator rst_n must be driven from ~rst
//  key_load        in   1    pulse: latch key_in, start expansion (honoured only in IDLE)
//  key_in          in   256  cipher key, [255:224] = w0 ... [31:0] = w7
//  rk_valid        out  1    round key valid
//  rk_ready        in   1    consumer accepts rk_data
//  rk_data         out  128  round key, [127:96] = first word
//  rk_idx          out  4    index of rk_data, 0..NUM_RK-1
//  busy            out  1    state != IDLE
//  done            out  1    1-cycle pulse after last round key accepted
//  gen_w0..gen_w7  out  32   window to generator (each)
//  gen_rcon_idx    out  3    to generator rcon_idx_in
//  gen_use_rcon    out  1    to generator use_rcon_in
//  gen_start       out  1    1-cycle start pulse to generator
//  gen_w8..gen_w11 in   32   generator result words (each)
//  gen_rcon_nxt    in   3    generator rcon_idx_out
//  gen_use_nxt     in   1    generator use_rcon_out
//  gen_done        in   1    generator done pulse
//  gen_sbox_in     in   8    generator S-box request byte
//  gen_sbox_out    out  8    S-box result to generator
//  cip_sbox_req    in   1    cipher datapath wants the S-box this cycle
//  cip_sbox_in     in   8    cipher S-box byte
//  cip_sbox_gnt    out  1    cipher owns S-box this cycle
//  cip_sbox_out    out  8    S-box result to cipher
//  sbox_in         out  8    to shared combinational S-box
//  sbox_out        in   8    from shared S-box
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs (rk_*, busy, done, gen_start, window, gen_owns) = 0.
//    gen_use_rcon=1; gen_rcon_idx=RCON_IDX0.
//  FSM: IDLE -> EMIT on key_load.
//    EMIT: rk_valid=1; hold rk_data/rk_idx until rk_valid&rk_ready.
//      Accept with rk_idx==NUM_RK-1 -> IDLE, done=1 next cycle.
//      Accept with rk_idx>=1 -> START.
//      Accept with rk_idx==0 -> EMIT with RK1 = w4..w7 (next cycle).
//    START: gen_start=1 for exactly one cycle -> WAIT.
//    WAIT: on gen_done:
//      rk_data <= {gen_w8..gen_w11}; rk_idx++.
//      window <= {w4..w7, gen_w8..gen_w11}.
//      gen_rcon_idx <= gen_rcon_nxt; gen_use_rcon <= gen_use_nxt.
//      -> EMIT.
//  key_load in IDLE: window <= key_in; rk_data <= key_in[255:128]; rk_idx=0.
//    gen_rcon_idx <= RCON_IDX0; gen_use_rcon <= 1.
//  Window, rcon_idx and use_rcon are stable from START through gen_done (generator reads w0..w3 at its last capture).
//  Latency: RK accepted at cycle A -> gen_start at A+1 -> gen_done at A+10 -> rk_valid at A+11.
//  key_load outside IDLE: ignored. gen_done outside WAIT: ignored. rk_ready while !rk_valid: ignored.
//  S-box arbitration: gen_owns is set on the cycle gen_start is high and cleared at the edge ending the gen_done cycle.
//    gen_owns=1 for A+2..A+10.
//    sbox_in = gen_owns ? gen_sbox_in : cip_sbox_in.
//    cip_sbox_gnt = cip_sbox_req & ~gen_owns (combinational).
//    gen_sbox_out = cip_sbox_out = sbox_out.
//    A denied cipher request retries; no queuing. The generator is never preempted.
//  Reset mid-expansion: FSM returns to IDLE; gen_owns=0; any partial round key is discarded.
// TESTING
//  FIPS-197 C.3 key 00010203..1e1f, rk_ready=1 -> RK0=000102030405060708090a0b0c0d0e0f, RK1=101112131415161718191a1b1c1d1e1f,
//    RK2=a573c29fa176c498a97fce93a572c09c, RK14=24fc79ccbf0979e9371ac23c6d68de36; done pulses once; busy low after.
//  rk_ready held low 20 cycles at RK3 -> rk_data/rk_idx stable; gen_start not asserted until accept; RK4 at accept+11.
//  cip_sbox_req=1 throughout expansion -> cip_sbox_gnt=0 exactly on gen_owns cycles (9 per generation); cip_sbox_out=S(cip_sbox_in) otherwise.
//  key_load pulsed during WAIT with a different key -> ignored; all 15 round keys match the first key.
//  rst asserted during WAIT of RK7 -> next cycle busy=0, rk_valid=0; a fresh key_load then yields the correct RK0..RK14.
//  NUM_RK=2 -> only RK0 and RK1 emitted; gen_start never asserted; done after second accept.

Source files
------------

// File: rtl/aes256_keyexp_ctrl.sv
// AES-256 key-expansion sequencer: drives a one-lane round-key generator,
// streams RK0..RK(NUM_RK-1) on valid/ready and arbitrates the shared S-box.
module aes256_keyexp_ctrl #(
    parameter int NUM_RK    = 15,
    parameter int RCON_IDX0 = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_key_load,
    input  logic [255:0] i_key_in,
    output logic         o_rk_valid,
    input  logic         i_rk_ready,
    output logic [127:0] o_rk_data,
    output logic [3:0]   o_rk_idx,
    output logic         o_busy,
    output logic         o_done,
    output logic [31:0]  o_gen_w0,
    output logic [31:0]  o_gen_w1,
    output logic [31:0]  o_gen_w2,
    output logic [31:0]  o_gen_w3,
    output logic [31:0]  o_gen_w4,
    output logic [31:0]  o_gen_w5,
    output logic [31:0]  o_gen_w6,
    output logic [31:0]  o_gen_w7,
    output logic [2:0]   o_gen_rcon_idx,
    output logic         o_gen_use_rcon,
    output logic         o_gen_start,
    input  logic [31:0]  i_gen_w8,
    input  logic [31:0]  i_gen_w9,
    input  logic [31:0]  i_gen_w10,
    input  logic [31:0]  i_gen_w11,
    input  logic [2:0]   i_gen_rcon_nxt,
    input  logic         i_gen_use_nxt,
    input  logic         i_gen_done,
    input  logic [7:0]   i_gen_sbox_in,
    output logic [7:0]   o_gen_sbox_out,
    input  logic         i_cip_sbox_req,
    input  logic [7:0]   i_cip_sbox_in,
    output logic         o_cip_sbox_gnt,
    output logic [7:0]   o_cip_sbox_out,
    output logic [7:0]   o_sbox_in,
    input  logic [7:0]   i_sbox_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_START,
        S_WAIT
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);
    localparam logic [2:0] RCON_RST = 3'(RCON_IDX0);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [255:0] r_win;
    logic [127:0] r_rk_data;
    logic [3:0]   r_rk_idx;
    logic [2:0]   r_rcon_idx;
    logic         r_use_rcon;
    logic         r_done;
    logic         r_gen_owns;

    logic w_load;
    logic w_step_hi;
    logic w_gen_fin;
    logic w_done_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step_hi   = 1'b0;
        w_gen_fin   = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_key_load) begin
                    w_state_nxt = S_EMIT;
                    w_load      = 1'b1;
                end
            end
            S_EMIT: begin
                if (i_rk_ready) begin
                    if (r_rk_idx == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_rk_idx == 4'd0) begin
                        // RK1 is the upper key half; no generator pass needed
                        w_step_hi = 1'b1;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_gen_done) begin
                    w_state_nxt = S_EMIT;
                    w_gen_fin   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win      <= '0;
            r_rk_data  <= '0;
            r_rk_idx   <= '0;
            r_rcon_idx <= RCON_RST;
            r_use_rcon <= 1'b1;
            r_done     <= 1'b0;
            r_gen_owns <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_load) begin
                r_win      <= i_key_in;
                r_rk_data  <= i_key_in[255:128];
                r_rk_idx   <= 4'd0;
                r_rcon_idx <= RCON_RST;
                r_use_rcon <= 1'b1;
            end
            if (w_step_hi) begin
                r_rk_data <= r_win[127:0];
                r_rk_idx  <= r_rk_idx + 4'd1;
            end
            if (w_gen_fin) begin
                r_rk_data  <= {i_gen_w8, i_gen_w9, i_gen_w10, i_gen_w11};
                r_rk_idx   <= r_rk_idx + 4'd1;
                r_win      <= {r_win[127:0], i_gen_w8, i_gen_w9,
                               i_gen_w10, i_gen_w11};
                r_rcon_idx <= i_gen_rcon_nxt;
                r_use_rcon <= i_gen_use_nxt;
            end
            // generator holds the S-box from the cycle after start to done
            if (r_state == S_START) begin
                r_gen_owns <= 1'b1;
            end else if (w_gen_fin) begin
                r_gen_owns <= 1'b0;
            end
        end
    end

    assign o_rk_valid     = (r_state == S_EMIT);
    assign o_busy         = (r_state != S_IDLE);
    assign o_gen_start    = (r_state == S_START);
    assign o_rk_data      = r_rk_data;
    assign o_rk_idx       = r_rk_idx;
    assign o_done         = r_done;
    assign o_gen_rcon_idx = r_rcon_idx;
    assign o_gen_use_rcon = r_use_rcon;

    assign o_gen_w0 = r_win[255:224];
    assign o_gen_w1 = r_win[223:192];
    assign o_gen_w2 = r_win[191:160];
    assign o_gen_w3 = r_win[159:128];
    assign o_gen_w4 = r_win[127:96];
    assign o_gen_w5 = r_win[95:64];
    assign o_gen_w6 = r_win[63:32];
    assign o_gen_w7 = r_win[31:0];

    assign o_sbox_in      = r_gen_owns ? i_gen_sbox_in : i_cip_sbox_in;
    assign o_cip_sbox_gnt = i_cip_sbox_req & ~r_gen_owns;
    assign o_gen_sbox_out = i_sbox_out;
    assign o_cip_sbox_out = i_sbox_out;

endmodule

// File: tb/tb_aes256_keyexp_ctrl.sv
// Bench for aes256_keyexp_ctrl: behavioural generator and S-box around the
// DUT, round keys checked against a plain FIPS-197 key-schedule model.
module tb_aes256_keyexp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, key_load, rk_valid, rk_ready, busy, done;
    logic [255:0] key_in;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic [31:0]  gen_w0, gen_w1, gen_w2, gen_w3;
    logic [31:0]  gen_w4, gen_w5, gen_w6, gen_w7;
    logic [2:0]   gen_rcon_idx, gen_rcon_nxt;
    logic         gen_use_rcon, gen_start, gen_use_nxt, gen_done;
    logic [31:0]  gen_w8, gen_w9, gen_w10, gen_w11;
    logic [7:0]   gen_sbox_in, gen_sbox_out, cip_sbox_in, cip_sbox_out;
    logic         cip_sbox_req, cip_sbox_gnt;
    logic [7:0]   sbox_in, sbox_out;

    logic         key_load2, rk_valid2, rk_ready2, busy2, done2;
    logic [127:0] rk_data2;
    logic [3:0]   rk_idx2;
    logic [31:0]  g2_w0, g2_w1, g2_w2, g2_w3, g2_w4, g2_w5, g2_w6, g2_w7;
    logic [2:0]   g2_rcon_idx;
    logic         g2_use, g2_start, cip2_gnt;
    logic [7:0]   g2_sbox_out, cip2_out, sbox_in2, sbox_out2;
    logic [31:0]  zero32 = '0;
    logic [2:0]   zero3 = '0;
    logic         zero1 = 1'b0;
    logic [7:0]   zero8 = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 0;
    int own_left = 0;
    bit g2_start_seen = 0;
    int gcnt = 0;

    logic [7:0]   sb_tab [256];
    logic [127:0] ref_rk [15];
    logic [127:0] got_rk [15];

    assign sbox_out  = sb_tab[sbox_in];
    assign sbox_out2 = sb_tab[sbox_in2];

    always @(posedge clk) cyc <= cyc + 1;

    aes256_keyexp_ctrl #(.NUM_RK(15), .RCON_IDX0(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_key_load(key_load), .i_key_in(key_in),
        .o_rk_valid(rk_valid), .i_rk_ready(rk_ready), .o_rk_data(rk_data),
        .o_rk_idx(rk_idx), .o_busy(busy), .o_done(done),
        .o_gen_w0(gen_w0), .o_gen_w1(gen_w1), .o_gen_w2(gen_w2),
        .o_gen_w3(gen_w3), .o_gen_w4(gen_w4), .o_gen_w5(gen_w5),
        .o_gen_w6(gen_w6), .o_gen_w7(gen_w7),
        .o_gen_rcon_idx(gen_rcon_idx), .o_gen_use_rcon(gen_use_rcon),
        .o_gen_start(gen_start),
        .i_gen_w8(gen_w8), .i_gen_w9(gen_w9), .i_gen_w10(gen_w10),
        .i_gen_w11(gen_w11), .i_gen_rcon_nxt(gen_rcon_nxt),
        .i_gen_use_nxt(gen_use_nxt), .i_gen_done(gen_done),
        .i_gen_sbox_in(gen_sbox_in), .o_gen_sbox_out(gen_sbox_out),
        .i_cip_sbox_req(cip_sbox_req), .i_cip_sbox_in(cip_sbox_in),
        .o_cip_sbox_gnt(cip_sbox_gnt), .o_cip_sbox_out(cip_sbox_out),
        .o_sbox_in(sbox_in), .i_sbox_out(sbox_out)
    );

    aes256_keyexp_ctrl #(.NUM_RK(2), .RCON_IDX0(0)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_key_load(key_load2), .i_key_in(key_in),
        .o_rk_valid(rk_valid2), .i_rk_ready(rk_ready2), .o_rk_data(rk_data2),
        .o_rk_idx(rk_idx2), .o_busy(busy2), .o_done(done2),
        .o_gen_w0(g2_w0), .o_gen_w1(g2_w1), .o_gen_w2(g2_w2),
        .o_gen_w3(g2_w3), .o_gen_w4(g2_w4), .o_gen_w5(g2_w5),
        .o_gen_w6(g2_w6), .o_gen_w7(g2_w7),
        .o_gen_rcon_idx(g2_rcon_idx), .o_gen_use_rcon(g2_use),
        .o_gen_start(g2_start),
        .i_gen_w8(zero32), .i_gen_w9(zero32), .i_gen_w10(zero32),
        .i_gen_w11(zero32), .i_gen_rcon_nxt(zero3),
        .i_gen_use_nxt(zero1), .i_gen_done(zero1),
        .i_gen_sbox_in(zero8), .o_gen_sbox_out(g2_sbox_out),
        .i_cip_sbox_req(zero1), .i_cip_sbox_in(zero8),
        .o_cip_sbox_gnt(cip2_gnt), .o_cip_sbox_out(cip2_out),
        .o_sbox_in(sbox_in2), .i_sbox_out(sbox_out2)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]],
                sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int c = 1; c < 256; c++) begin
                    if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
                end
            end
            sb_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                        ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // straight FIPS-197 schedule over the whole 60-word array
    task automatic compute_ref(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // behavioural one-lane generator: done 9 cycles after start
    always @(negedge clk) begin
        logic [31:0] t;
        logic [7:0]  rcv;
        if (rst) begin
            gcnt = 0;
            gen_done = 1'b0;
            gen_w8 = '0; gen_w9 = '0; gen_w10 = '0; gen_w11 = '0;
            gen_rcon_nxt = '0;
            gen_use_nxt = 1'b0;
        end else begin
            gen_done = 1'b0;
            if (gcnt != 0) begin
                gcnt--;
                if (gcnt == 0) begin
                    t = gen_w7;
                    rcv = 8'(32'd1 << gen_rcon_idx);
                    if (gen_use_rcon) t = subw({t[23:0], t[31:24]}) ^ {rcv, 24'h0};
                    else t = subw(t);
                    gen_w8  = gen_w0 ^ t;
                    gen_w9  = gen_w1 ^ gen_w8;
                    gen_w10 = gen_w2 ^ gen_w9;
                    gen_w11 = gen_w3 ^ gen_w10;
                    gen_rcon_nxt = gen_use_rcon ? gen_rcon_idx + 3'd1 : gen_rcon_idx;
                    gen_use_nxt = ~gen_use_rcon;
                    gen_done = 1'b1;
                end
            end else if (!gen_start && $urandom_range(0, 5) == 0) begin
                gen_w8 = $urandom; gen_w9 = $urandom;
                gen_w10 = $urandom; gen_w11 = $urandom;
                gen_rcon_nxt = 3'($urandom);
                gen_use_nxt = 1'($urandom);
                gen_done = 1'b1;
            end
            if (gen_start) gcnt = 9;
        end
    end

    task automatic monitor();
        bit exp_own;
        logic exp_gnt;
        logic [7:0] exp_sb;
        forever begin
            @(negedge clk);
            exp_own = (own_left != 0);
            if (mon_en) begin
                exp_gnt = cip_sbox_req & ~exp_own;
                total++;
                if (cip_sbox_gnt !== exp_gnt) begin
                    bad++;
                    $display("FAIL cip_gnt cyc=%0d got=%b exp=%b", cyc, cip_sbox_gnt, exp_gnt);
                end
                exp_sb = sb_tab[exp_own ? gen_sbox_in : cip_sbox_in];
                total++;
                if (cip_sbox_out !== exp_sb || gen_sbox_out !== exp_sb) begin
                    bad++;
                    $display("FAIL sbox_route cyc=%0d got=%h/%h exp=%h",
                             cyc, cip_sbox_out, gen_sbox_out, exp_sb);
                end
            end
            if (own_left != 0) own_left--;
            if (gen_start) own_left = 9;
            if (rst) own_left = 0;
            if (g2_start) g2_start_seen = 1;
            gen_sbox_in  = 8'($urandom);
            cip_sbox_in  = 8'($urandom);
            cip_sbox_req = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic expand(input logic [255:0] k, input int stall_at,
                          input int inject_at, input int abort_at);
        int acc, wt, gs_cyc, lat;
        compute_ref(k);
        for (int i = 0; i < 15; i++) got_rk[i] = '0;
        @(posedge clk); #1;
        key_in = k;
        key_load = 1'b1;
        acc = cyc;
        @(posedge clk); #1;
        key_load = 1'b0;
        key_in = rand256();
        for (int n = 0; n < 15; n++) begin
            wt = 0;
            gs_cyc = -1;
            while (rk_valid !== 1'b1 && wt < 40) begin
                if (gen_start === 1'b1) gs_cyc = cyc;
                key_load = (n == inject_at && wt == 4);
                if (key_load) key_in = ~k;
                if (n == abort_at && wt == 5) begin
                    rk_ready = 1'b0;
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    total++;
                    if ({busy, rk_valid, gen_use_rcon, gen_rcon_idx} !== 6'b001000) begin
                        bad++;
                        $display("FAIL abort_rst got=%b%b%b%0d exp=001 0",
                                 busy, rk_valid, gen_use_rcon, gen_rcon_idx);
                    end
                    return;
                end
                rk_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                wt++;
            end
            key_load = 1'b0;
            rk_ready = 1'b0;
            total++;
            if (rk_valid !== 1'b1) begin
                bad++;
                $display("FAIL rk_timeout idx=%0d got=%b exp=1", n, rk_valid);
                return;
            end
            lat = cyc - acc;
            total++;
            if (lat != ((n <= 1) ? 1 : 11)) begin
                bad++;
                $display("FAIL latency idx=%0d got=%0d exp=%0d", n, lat, (n <= 1) ? 1 : 11);
            end
            if (n >= 2) begin
                total++;
                if (gs_cyc - acc != 1) begin
                    bad++;
                    $display("FAIL start_time idx=%0d got=%0d exp=1", n, gs_cyc - acc);
                end
            end
            if (n == 0) begin
                total++;
                if ({gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7} !== k) begin
                    bad++;
                    $display("FAIL window_load got=%h exp=%h",
                             {gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7}, k);
                end
            end
            got_rk[n] = rk_data;
            total++;
            if (rk_idx !== 4'(n)) begin
                bad++;
                $display("FAIL rk_idx got=%0d exp=%0d", rk_idx, n);
            end
            total++;
            if (rk_data !== ref_rk[n]) begin
                bad++;
                $display("FAIL rk_data idx=%0d got=%h exp=%h", n, rk_data, ref_rk[n]);
            end
            total++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL early_done idx=%0d got=%b%b exp=01", n, done, busy);
            end
            if (n == stall_at) begin
                for (int s = 0; s < 20; s++) begin
                    @(posedge clk); #1;
                    total++;
                    if (rk_valid !== 1'b1 || gen_start !== 1'b0 ||
                        rk_idx !== 4'(n) || rk_data !== got_rk[n]) begin
                        bad++;
                        $display("FAIL stall s=%0d got=%b%b %0d %h exp=10 %0d %h",
                                 s, rk_valid, gen_start, rk_idx, rk_data, n, got_rk[n]);
                    end
                end
            end
            rk_ready = 1'b1;
            acc = cyc;
            @(posedge clk); #1;
            rk_ready = 1'b0;
        end
        total++;
        if ({done, busy, rk_valid} !== 3'b100) begin
            bad++;
            $display("FAIL done_pulse got=%b%b%b exp=100", done, busy, rk_valid);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_once got=%b exp=0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rk_valid, busy, done, gen_start} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_ctrl got=%b%b%b%b exp=0000", rk_valid, busy, done, gen_start);
        end
        total++;
        if (rk_data !== '0 || rk_idx !== '0) begin
            bad++;
            $display("FAIL rst_rk got=%h/%0d exp=0/0", rk_data, rk_idx);
        end
        total++;
        if (gen_use_rcon !== 1'b1 || gen_rcon_idx !== 3'd0) begin
            bad++;
            $display("FAIL rst_rcon got=%b/%0d exp=1/0", gen_use_rcon, gen_rcon_idx);
        end
        total++;
        if ({gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7} !== '0) begin
            bad++;
            $display("FAIL rst_window got=%h exp=0", {gen_w0, gen_w7});
        end
        total++;
        if (cip_sbox_gnt !== cip_sbox_req) begin
            bad++;
            $display("FAIL rst_gnt got=%b exp=%b", cip_sbox_gnt, cip_sbox_req);
        end
        total++;
        if ({rk_valid2, busy2, done2} !== 3'b000) begin
            bad++;
            $display("FAIL rst_dut2 got=%b%b%b exp=000", rk_valid2, busy2, done2);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fips();
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, -1, -1, -1);
        total++;
        if (got_rk[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
            bad++;
            $display("FAIL fips_rk0 got=%h exp=000102030405060708090a0b0c0d0e0f", got_rk[0]);
        end
        total++;
        if (got_rk[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin
            bad++;
            $display("FAIL fips_rk1 got=%h exp=101112131415161718191a1b1c1d1e1f", got_rk[1]);
        end
        total++;
        if (got_rk[2] !== 128'ha573c29fa176c498a97fce93a572c09c) begin
            bad++;
            $display("FAIL fips_rk2 got=%h exp=a573c29fa176c498a97fce93a572c09c", got_rk[2]);
        end
        total++;
        if (got_rk[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            bad++;
            $display("FAIL fips_rk14 got=%h exp=24fc79ccbf0979e9371ac23c6d68de36", got_rk[14]);
        end
    endtask

    task automatic test_stall();
        expand(rand256(), 3, -1, -1);
    endtask

    task automatic test_inject();
        expand(rand256(), -1, 5, -1);
    endtask

    task automatic test_reset_mid();
        expand(rand256(), -1, -1, 7);
        expand(rand256(), -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        repeat (2) expand(rand256(), -1, -1, -1);
    endtask

    task automatic test_num2();
        logic [255:0] k;
        k = rand256();
        compute_ref(k);
        @(posedge clk); #1;
        key_in = k;
        key_load2 = 1'b1;
        @(posedge clk); #1;
        key_load2 = 1'b0;
        key_in = rand256();
        total++;
        if (rk_valid2 !== 1'b1 || rk_idx2 !== 4'd0 || rk_data2 !== ref_rk[0]) begin
            bad++;
            $display("FAIL n2_rk0 got=%b %0d %h exp=1 0 %h", rk_valid2, rk_idx2, rk_data2, ref_rk[0]);
        end
        total++;
        if ({g2_w0, g2_w1, g2_w2, g2_w3, g2_w4, g2_w5, g2_w6, g2_w7} !== k) begin
            bad++;
            $display("FAIL n2_window got=%h exp=%h", {g2_w0, g2_w7}, {k[255:224], k[31:0]});
        end
        total++;
        if ({g2_sbox_out, cip2_out, cip2_gnt, g2_use, g2_rcon_idx} !== {sb_tab[0], sb_tab[0], 1'b0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL n2_side got=%h %h %b %b %0d exp=%h %h 0 1 0",
                     g2_sbox_out, cip2_out, cip2_gnt, g2_use, g2_rcon_idx, sb_tab[0], sb_tab[0]);
        end
        rk_ready2 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rk_valid2 !== 1'b1 || rk_idx2 !== 4'd1 || rk_data2 !== ref_rk[1]) begin
            bad++;
            $display("FAIL n2_rk1 got=%b %0d %h exp=1 1 %h", rk_valid2, rk_idx2, rk_data2, ref_rk[1]);
        end
        @(posedge clk); #1;
        rk_ready2 = 1'b0;
        total++;
        if ({done2, busy2, rk_valid2} !== 3'b100) begin
            bad++;
            $display("FAIL n2_done got=%b%b%b exp=100", done2, busy2, rk_valid2);
        end
        @(posedge clk); #1;
        total++;
        if (done2 !== 1'b0 || g2_start_seen !== 1'b0) begin
            bad++;
            $display("FAIL n2_nostart got=%b%b exp=00", done2, g2_start_seen);
        end
    endtask

    initial begin
        rst = 1'b1;
        key_load = 1'b0;
        key_in = '0;
        rk_ready = 1'b0;
        key_load2 = 1'b0;
        rk_ready2 = 1'b0;
        cip_sbox_req = 1'b0;
        cip_sbox_in = '0;
        gen_sbox_in = '0;
        build_sbox();
        fork
            monitor();
        join_none
        test_reset();
        test_fips();
        test_stall();
        test_inject();
        test_reset_mid();
        test_back_to_back();
        test_num2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
